ctrl_step_sequencer: RTL
========================

// Module: ctrl_step_sequencer
// PURPOSE
//  Parametrised multi-cycle step sequencer for the MiniSRC control path. It generalises the fixed
//  5-step ring into an N-step one-hot counter. It owns the IR and terminates each instruction early
//  at its opcode-specific last step. It supports iRdy stalls, HLT with resume, illegal-opcode
//  flagging and a retired-instruction count. Step decode logic downstream consumes oStep and oIR.
// PARAMETERS
//  NUM_STEPS    8   max steps per instruction (T0..T(N-1)); legal range 5..16
//  FETCH_STEPS  3   fetch steps T0..T(F-1); IR loads at the end of T(F-1); legal range 2..NUM_STEPS-2
//  DATA_W       32  instruction/memory data width
//  OP_W         5   opcode width; opcode = oIR[DATA_W-1 -: OP_W]
// PORTS
//  iClk        in   1          clock; all state updates on the rising edge
//  iRst        in   1          synchronous active-high reset
//  iRdy        in   1          step-advance enable; low = freeze all state (memory wait)
//  iRun        in   1          one-cycle resume request while halted
//  iMemData    in   DATA_W     instruction word from memory data path
//  oStep       out  NUM_STEPS  one-hot current step; bit k = Tk
//  oIR_en      out  1          IR load strobe (combinational)
//  oIR         out  DATA_W     instruction register
//  oOpCode     out  OP_W       opcode field of oIR
//  oIllegal    out  1          undefined opcode in execute steps
//  oInsDone    out  1          last step of instruction completing this cycle
//  oHalted     out  1          sequencer halted
//  oInsCount   out  32         retired-instruction counter
// BEHAVIOUR
//  Reset: oStep=1 (T0), oIR=0, oHalted=0, oInsCount=0. All outputs are derived from the reset state,
//   so oIR_en=0, oIllegal=0 and oInsDone=0. iRst has priority over every other input.
//  States: RUN (oHalted=0) and HALT (oHalted=1). adv = RUN & iRdy.
//  oIR_en = adv & oStep[FETCH_STEPS-1]. On that edge oIR <= iMemData.
//  Length table L(op), counting the fetch steps. Last step index = min(FETCH_STEPS+L(op)-1, NUM_STEPS-1).
//   - LD=00000: L=4. LI=00001: L=2. ST=00010: L=3.
//   - ADD..SLL (00011-01011), ADDI/ANDI/ORI, NEG, NOT: L=2.
//   - DIV=01111 and MUL=10000: L=3. BRx=10011: L=3.
//   - JAL=10100: L=2. JFR=10101, MFL=11000, MFH=11001: L=1.
//   - NOP=11010 and HLT=11011: L=1.
//   - Undefined opcodes (10110, 10111, 11100-11111): L=1.
//  Termination is evaluated only when the step index is >= FETCH_STEPS. A stale IR in fetch steps
//   never ends an instruction.
//  On adv, at a non-last step: oStep shifts left by one.
//  On adv, at the last step: oStep <= T0, oInsDone=1 (combinational, same cycle) and oInsCount+1.
//   oInsCount wraps 2^32-1 -> 0.
//  HLT last step: the instruction retires normally, oStep <= T0 and the state becomes HALT on the same edge.
//  HALT: oStep holds T0; oIR_en=0, oInsDone=0 and oInsCount is frozen.
//   If iRun=1 on an edge: RUN from the next cycle, and fetch restarts at T0.
//   iRun in RUN is ignored.
//  iRdy=0 in RUN: oStep, oIR and oInsCount hold; oIR_en=0 and oInsDone=0.
//  oIllegal = RUN & (step index >= FETCH_STEPS) & opcode undefined. Illegal instructions retire like NOP.
//  Reset mid-instruction or while halted returns to the reset state on the next edge, with no retire.
//  Invariant: oStep is always exactly one-hot.
// TESTING
//  1. Reset then ADD (0x18000000) with iRdy=1 -> oStep T0..T4; IR loads at T2; oInsDone at T4;
//     oInsCount=1; back to T0.
//  2. LD (0x00000000) with iRdy low for 3 cycles at T1 -> oStep holds T1 for 3 cycles and oIR_en stays 0.
//     Then T2..T6; oInsDone at T6.
//  3. HLT (0xD8000000) -> oInsDone at T3, then oHalted=1 with oStep=T0. 10 idle cycles leave no change.
//     An iRun pulse -> oHalted=0 and fetch resumes at T0 next cycle.
//  4. Opcode 11111 -> oIllegal=1 during T3 only; retires at T3; oInsCount increments.
//  5. NUM_STEPS=6, LD -> last step clamped to T5. Separately, preload oInsCount to 0xFFFFFFFF and retire
//     one instruction -> oInsCount reads 0.
//  6. iRst asserted at T3 of a MUL, together with iRun -> next cycle in reset state: oStep=1, oIR=0,
//     oInsCount unchanged from 0, oHalted=0.

Source files
------------

// File: rtl/ctrl_step_sequencer_if.sv
// Interface bundling the sequencer's handshake and data signals.
//   slave  : seen by the sequencer (iRdy/iRun/iMemData in, step/IR/status out)
//   master : seen by whatever drives the sequencer and consumes its outputs
interface ctrl_step_sequencer_if #(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OP_W      = 5
);
  localparam int unsigned CNT_W = 32;

  logic                 iRdy;
  logic                 iRun;
  logic [DATA_W-1:0]    iMemData;
  logic [NUM_STEPS-1:0] oStep;
  logic                 oIR_en;
  logic [DATA_W-1:0]    oIR;
  logic [OP_W-1:0]      oOpCode;
  logic                 oIllegal;
  logic                 oInsDone;
  logic                 oHalted;
  logic [CNT_W-1:0]     oInsCount;

  modport slave (
    input  iRdy, iRun, iMemData,
    output oStep, oIR_en, oIR, oOpCode, oIllegal, oInsDone, oHalted, oInsCount
  );

  modport master (
    output iRdy, iRun, iMemData,
    input  oStep, oIR_en, oIR, oOpCode, oIllegal, oInsDone, oHalted, oInsCount
  );
endinterface

// File: rtl/ctrl_step_sequencer.sv
// N-step one-hot control step sequencer for the MiniSRC control path.
// Owns the IR, ends each instruction at its opcode-specific last step, stalls on
// iRdy low, halts on HLT until an iRun pulse, flags undefined opcodes and counts
// retired instructions.
// Ports:
//   iClk, iRst       clock, synchronous active-high reset
//   bus (slave)      iRdy, iRun, iMemData in; oStep, oIR_en, oIR, oOpCode,
//                    oIllegal, oInsDone, oHalted, oInsCount out
//   oIR_en, oInsDone and oIllegal are combinational decodes of state and inputs.
module ctrl_step_sequencer #(
  parameter int unsigned NUM_STEPS   = 8,
  parameter int unsigned FETCH_STEPS = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OP_W        = 5
) (
  input  logic iClk,
  input  logic iRst,
  ctrl_step_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LEN_W = 3;
  localparam logic [4:0]  OP_HLT = 5'b11011;

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [NUM_STEPS-1:0] step_q, step_d;
  logic [DATA_W-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0]     ins_count_q, ins_count_d;

  logic [OP_W-1:0]      opcode;
  logic [4:0]           op5;
  logic [LEN_W-1:0]     op_len;
  logic                 op_undef;
  logic [IDX_W-1:0]     step_idx;
  logic [IDX_W-1:0]     last_full;
  logic [IDX_W-1:0]     last_idx;
  logic                 in_exec;
  logic                 at_last;
  logic                 adv_c;
  logic                 ir_en_c;
  logic                 ins_done_c;

  assign opcode = ir_q[DATA_W-1 -: OP_W];
  assign op5    = 5'(opcode);

  // Instruction length in steps (fetch included) and undefined-opcode decode.
  always_comb begin
    op_len   = LEN_W'(1);
    op_undef = 1'b0;
    case (op5) inside
      5'd0:           op_len = LEN_W'(4);
      5'd1:           op_len = LEN_W'(2);
      5'd2:           op_len = LEN_W'(3);
      [5'd3:5'd14]:   op_len = LEN_W'(2);
      5'd15, 5'd16:   op_len = LEN_W'(3);
      5'd17, 5'd18:   op_len = LEN_W'(2);
      5'd19:          op_len = LEN_W'(3);
      5'd20:          op_len = LEN_W'(2);
      5'd22, 5'd23,
      [5'd28:5'd31]:  op_undef = 1'b1;
      default:        op_len = LEN_W'(1);
    endcase
  end

  // One-hot to index.
  always_comb begin
    step_idx = '0;
    for (int unsigned k = 0; k < NUM_STEPS; k++) begin
      if (step_q[k]) step_idx = IDX_W'(k);
    end
  end

  // Last step is clamped so the one-hot never shifts past T(N-1).
  assign last_full = IDX_W'(FETCH_STEPS) + IDX_W'(op_len) - IDX_W'(1);
  assign last_idx  = (last_full > IDX_W'(NUM_STEPS - 1)) ? IDX_W'(NUM_STEPS - 1) : last_full;

  // Termination only in execute steps, so a stale IR during fetch is ignored.
  assign in_exec    = (step_idx >= IDX_W'(FETCH_STEPS));
  assign at_last    = in_exec && (step_idx >= last_idx);
  assign adv_c      = !iRst && (state_q == S_RUN) && bus.iRdy;
  assign ir_en_c    = adv_c && step_q[FETCH_STEPS-1];
  assign ins_done_c = adv_c && at_last;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ir_d        = ir_q;
    ins_count_d = ins_count_q;
    case (state_q)
      S_RUN: begin
        if (adv_c) begin
          if (ir_en_c) ir_d = bus.iMemData;
          if (at_last) begin
            step_d      = NUM_STEPS'(1);
            ins_count_d = ins_count_q + CNT_W'(1);
            if (op5 == OP_HLT) state_d = S_HALT;
          end else begin
            step_d = {step_q[NUM_STEPS-2:0], 1'b0};
          end
        end
      end
      S_HALT: begin
        if (bus.iRun) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // State registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_RUN;
      step_q      <= NUM_STEPS'(1);
      ir_q        <= '0;
      ins_count_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ir_q        <= ir_d;
      ins_count_q <= ins_count_d;
    end
  end

  assign bus.oStep     = step_q;
  assign bus.oIR_en    = ir_en_c;
  assign bus.oIR       = ir_q;
  assign bus.oOpCode   = opcode;
  assign bus.oIllegal  = (state_q == S_RUN) && in_exec && op_undef;
  assign bus.oInsDone  = ins_done_c;
  assign bus.oHalted   = (state_q == S_HALT);
  assign bus.oInsCount = ins_count_q;

endmodule
